// File: rtl/res_packer.sv
// Result packer: captures NUM result samples LSB-first into one wide package
// and hands it to the bench over a valid/ready handshake.
module res_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM    = 100,
  parameter int unsigned DROP_W = 16,
  localparam int unsigned PACKAGE_WIDTH = NUM * DATA_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic                     continuous_i,
  input  logic [DATA_W-1:0]        res_i,
  input  logic                     res_valid_i,
  output logic [PACKAGE_WIDTH-1:0] pkg_o,
  output logic                     pkg_valid_o,
  input  logic                     pkg_ready_i,
  output logic [7:0]               count_o,
  output logic                     busy_o,
  output logic [DROP_W-1:0]        drop_cnt_o
);

  localparam logic [7:0] LastCnt = 8'(NUM - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e                   state_q, state_d;
  logic [PACKAGE_WIDTH-1:0] shreg_q, shreg_d;
  logic [PACKAGE_WIDTH-1:0] pkg_q, pkg_d;
  logic                     pkg_valid_q, pkg_valid_d;
  logic [7:0]               count_q, count_d;
  logic [DROP_W-1:0]        drop_q, drop_d;

  // Next-state and datapath updates; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    pkg_d       = pkg_q;
    pkg_valid_d = pkg_valid_q;
    count_d     = count_q;
    drop_d      = drop_q;
    if (abort_i) begin
      // pkg_q kept so a previously delivered package is not disturbed.
      state_d     = StIdle;
      pkg_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A sample arriving with the arm pulse is not captured.
          if (arm_i) begin
            state_d = StCollect;
            shreg_d = '0;
            count_d = '0;
          end
        end
        StCollect: begin
          if (res_valid_i) begin
            shreg_d = {res_i, shreg_q[PACKAGE_WIDTH-1:DATA_W]};
            count_d = count_q + 8'd1;
            if (count_q == LastCnt) begin
              state_d     = StHold;
              pkg_d       = {res_i, shreg_q[PACKAGE_WIDTH-1:DATA_W]};
              pkg_valid_d = 1'b1;
            end
          end
        end
        StHold: begin
          // Samples arriving while the package is held are lost, even on the
          // handshake edge, so packages never straddle a handshake.
          if (res_valid_i && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
          end
          if (pkg_valid_q && pkg_ready_i) begin
            pkg_valid_d = 1'b0;
            count_d     = '0;
            if (continuous_i) begin
              state_d = StCollect;
              shreg_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      pkg_q       <= '0;
      pkg_valid_q <= 1'b0;
      count_q     <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pkg_q       <= pkg_d;
      pkg_valid_q <= pkg_valid_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    pkg_o       = pkg_q;
    pkg_valid_o = pkg_valid_q;
    count_o     = count_q;
    busy_o      = (state_q == StCollect);
    drop_cnt_o  = drop_q;
  end

endmodule
